dtw_sched: RTL and testbench

- Query scheduler/sequencer for dtw_core.
- Pulls squiggle samples from the AXIS-fed source FIFO and writes SQG_SIZE samples into the core's query buffer.
- Pulses the core start, waits for completion with a watchdog, then pushes {minval, position, qid} into the sink FIFO.
- Sits between the AXIS slave FIFO, dtw_core and the result FIFO; enabled from the AXI-Lite control register.

---
 rtl/dtw_pkg.sv | 18 +
 rtl/dtw_wdog.sv | 26 ++
 rtl/dtw_sched.sv | 169 ++++++++++++++++
 tb/tb_dtw_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared types and default sizing for the dtw_core query scheduler.
package dtw_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, EMIT} state_t;

    localparam int DEF_WIDTH          = 16;
    localparam int DEF_SQG_SIZE       = 250;
    localparam int DEF_AXI_DWIDTH     = 32;
    localparam int DEF_QID_W          = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1 << 24;

    typedef struct packed {
        logic [DEF_AXI_DWIDTH-1:0] minval;
        logic [DEF_AXI_DWIDTH-1:0] position;
        logic [DEF_QID_W-1:0]      qid;
    } result_t;

endpackage

// File: rtl/dtw_wdog.sv
// Free-running WAIT watchdog: cleared on start, counts while enabled, flags the last allowed cycle.
module dtw_wdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign expire_o = (cnt_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dtw_sched.sv
// Query sequencer: source FIFO -> core query buffer, start/wait with watchdog, result -> sink FIFO.
module dtw_sched
    import dtw_pkg::*;
#(
    parameter int width          = DEF_WIDTH,
    parameter int SQG_SIZE       = DEF_SQG_SIZE,
    parameter int axi_dwidth     = DEF_AXI_DWIDTH,
    parameter int QID_W          = DEF_QID_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        src_fifo_empty,
    output logic                        src_fifo_rden,
    input  logic [width-1:0]            src_fifo_data,
    output logic                        core_load_en,
    output logic [$clog2(SQG_SIZE)-1:0] core_load_addr,
    output logic [width-1:0]            core_load_data,
    output logic                        core_start,
    output logic                        core_abort,
    input  logic                        core_done,
    input  logic [axi_dwidth-1:0]       core_minval,
    input  logic [axi_dwidth-1:0]       core_position,
    input  logic                        sink_fifo_full,
    output logic                        sink_fifo_wren,
    output logic [axi_dwidth-1:0]       sink_minval,
    output logic [axi_dwidth-1:0]       sink_position,
    output logic [QID_W-1:0]            sink_qid,
    output logic                        running,
    output logic                        err_timeout,
    output logic [QID_W-1:0]            qid_count
);

    localparam int ADDR_W = $clog2(SQG_SIZE);
    localparam int RD_W   = $clog2(SQG_SIZE + 1);

    state_t                state_q, state_d;
    logic [RD_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic [QID_W-1:0]      qid_q, qid_d;
    logic                  rd_vld_q;
    logic                  load_en_q;
    logic [ADDR_W-1:0]     load_addr_q;
    logic [width-1:0]      load_data_q;
    logic [axi_dwidth-1:0] minval_q, position_q;
    logic                  err_q;

    logic rden, start, abort, wren, latch_res, set_err;
    logic wdog_clr, wdog_run, wdog_expire;

    dtw_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wdog_clr),
        .en_i     (wdog_run),
        .expire_o (wdog_expire)
    );

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        qid_d     = qid_q;
        rden      = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        wren      = 1'b0;
        latch_res = 1'b0;
        set_err   = 1'b0;
        wdog_clr  = 1'b0;
        wdog_run  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = LOAD;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end
            end
            LOAD: begin
                // Read count caps the query, so the FIFO is never over-drained.
                rden = !src_fifo_empty && (rd_cnt_q < RD_W'(SQG_SIZE));
                if (rden) rd_cnt_d = rd_cnt_q + RD_W'(1);
                if (rd_vld_q) begin
                    wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    if (wr_cnt_q == ADDR_W'(SQG_SIZE - 1)) state_d = START;
                end
            end
            START: begin
                start    = 1'b1;
                wdog_clr = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                wdog_run = 1'b1;
                if (core_done) begin
                    latch_res = 1'b1;
                    state_d   = EMIT;
                end else if (wdog_expire) begin
                    abort   = 1'b1;
                    set_err = 1'b1;
                    state_d = IDLE;
                end
            end
            EMIT: begin
                if (!sink_fifo_full) begin
                    wren  = 1'b1;
                    qid_d = qid_q + QID_W'(1);
                    if (enable) begin
                        state_d  = LOAD;
                        rd_cnt_d = '0;
                        wr_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            qid_q       <= '0;
            rd_vld_q    <= 1'b0;
            load_en_q   <= 1'b0;
            load_addr_q <= '0;
            load_data_q <= '0;
            minval_q    <= '0;
            position_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            qid_q     <= qid_d;
            rd_vld_q  <= rden;
            load_en_q <= (state_q == LOAD) && rd_vld_q;
            if ((state_q == LOAD) && rd_vld_q) begin
                load_addr_q <= wr_cnt_q;
                load_data_q <= src_fifo_data;
            end
            if (latch_res) begin
                minval_q   <= core_minval;
                position_q <= core_position;
            end
            if (set_err) err_q <= 1'b1;
        end
    end

    assign src_fifo_rden  = rden;
    assign core_load_en   = load_en_q;
    assign core_load_addr = load_addr_q;
    assign core_load_data = load_data_q;
    assign core_start     = start;
    assign core_abort     = abort;
    assign sink_fifo_wren = wren;
    assign sink_minval    = minval_q;
    assign sink_position  = position_q;
    assign sink_qid       = qid_q;
    assign running        = (state_q != IDLE);
    assign err_timeout    = err_q;
    assign qid_count      = qid_q;

endmodule

// File: tb/tb_dtw_sched.sv
// Scoreboarded bench for dtw_sched with a FIFO/core/sink model (SQG_SIZE=4, TIMEOUT=16, QID_W=2).
module tb_dtw_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        src_fifo_empty = 1'b1;
    logic        src_fifo_rden;
    logic [15:0] src_fifo_data = '0;
    logic        core_load_en;
    logic [1:0]  core_load_addr;
    logic [15:0] core_load_data;
    logic        core_start, core_abort;
    logic        core_done = 1'b0;
    logic [31:0] core_minval = '0, core_position = '0;
    logic        sink_fifo_full = 1'b0;
    logic        sink_fifo_wren;
    logic [31:0] sink_minval, sink_position;
    logic [1:0]  sink_qid;
    logic        running, err_timeout;
    logic [1:0]  qid_count;

    dtw_sched #(.width(16), .SQG_SIZE(4), .axi_dwidth(32), .QID_W(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .src_fifo_empty(src_fifo_empty), .src_fifo_rden(src_fifo_rden), .src_fifo_data(src_fifo_data),
        .core_load_en(core_load_en), .core_load_addr(core_load_addr), .core_load_data(core_load_data),
        .core_start(core_start), .core_abort(core_abort), .core_done(core_done),
        .core_minval(core_minval), .core_position(core_position),
        .sink_fifo_full(sink_fifo_full), .sink_fifo_wren(sink_fifo_wren),
        .sink_minval(sink_minval), .sink_position(sink_position), .sink_qid(sink_qid),
        .running(running), .err_timeout(err_timeout), .qid_count(qid_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] mv;
        logic [31:0] pos;
        logic [1:0]  qid;
    } res_t;

    int   n_tests = 0, n_fail = 0, cyc = 0;
    int   n_rden = 0, n_load = 0, n_start = 0, n_abort = 0, n_wr = 0;
    int   ld_in_q = 0, first_ld = 0, last_ld = 0, abort_at = 0;
    int   wait_ctr = 0, core_delay = 0;
    bit   pop_pending = 0, core_busy = 0;
    logic [1:0]  exp_addr = '0, exp_qid = '0;
    logic [31:0] mv = '0, pos = '0;
    logic [15:0] src_q[$];
    logic [15:0] exp_ld[$];
    res_t        exp_res[$];

    // Observes the DUT mid-cycle and updates the scoreboard/counters.
    task automatic monitor();
        logic [15:0] ed;
        res_t        er;
        if (rst) return;
        if (src_fifo_rden) begin
            n_rden++;
            pop_pending = 1;
            if (src_fifo_empty) begin
                n_tests++; n_fail++;
                $display("FAIL rden_when_empty cyc=%0d got rden=1 want 0", cyc);
            end
        end
        if (core_load_en) begin
            n_tests++;
            if (exp_ld.size() == 0) begin
                n_fail++;
                $display("FAIL load_unexpected cyc=%0d addr=%0d data=%0d", cyc, core_load_addr, core_load_data);
            end else begin
                ed = exp_ld.pop_front();
                if (core_load_addr !== exp_addr || core_load_data !== ed) begin
                    n_fail++;
                    $display("FAIL load cyc=%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                             cyc, core_load_addr, core_load_data, exp_addr, ed);
                end
            end
            exp_addr++;
            ld_in_q++;
            n_load++;
            if (ld_in_q == 1) first_ld = cyc;
            last_ld = cyc;
        end
        if (core_start) begin
            n_tests++;
            if (ld_in_q !== 4) begin
                n_fail++;
                $display("FAIL start_after_load cyc=%0d got loads=%0d want 4", cyc, ld_in_q);
            end
            ld_in_q = 0; n_start++; core_busy = 1; wait_ctr = 0;
        end
        if (core_abort) begin
            n_abort++; abort_at = wait_ctr; core_busy = 0;
        end
        if (sink_fifo_wren) begin
            n_wr++;
            n_tests++;
            if (exp_res.size() == 0) begin
                n_fail++;
                $display("FAIL wren_unexpected cyc=%0d", cyc);
            end else begin
                er = exp_res.pop_front();
                if ({sink_minval, sink_position, sink_qid} !== er) begin
                    n_fail++;
                    $display("FAIL result cyc=%0d got mv=%0d pos=%0d qid=%0d want mv=%0d pos=%0d qid=%0d",
                             cyc, sink_minval, sink_position, sink_qid, er.mv, er.pos, er.qid);
                end
            end
        end
    endtask

    // One clock: sample at negedge, then drive FIFO/core model just after posedge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (pop_pending) begin
            if (src_q.size() != 0) src_fifo_data = src_q.pop_front();
            pop_pending = 0;
        end
        src_fifo_empty = (src_q.size() == 0);
        core_done = 1'b0;
        if (core_busy) begin
            wait_ctr++;
            if (wait_ctr == core_delay) begin
                core_done = 1'b1; core_minval = mv; core_position = pos;
                exp_res.push_back({mv, pos, exp_qid});
                exp_qid++; mv++; core_busy = 0;
            end
        end
    endtask

    task automatic push(input logic [15:0] v);
        src_q.push_back(v);
        exp_ld.push_back(v);
        src_fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; sink_fifo_full = 1'b0;
        repeat (2) step();
        src_q.delete(); exp_ld.delete(); exp_res.delete();
        src_fifo_empty = 1'b1;
        exp_addr = '0; exp_qid = '0; core_busy = 0; ld_in_q = 0; pop_pending = 0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({src_fifo_rden, core_load_en, core_load_addr, core_load_data, core_start, core_abort,
             sink_fifo_wren, sink_minval, sink_position, sink_qid, running, err_timeout, qid_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got running=%0d err=%0d qid=%0d load_en=%0d want all 0",
                     running, err_timeout, qid_count, core_load_en);
        end
    endtask

    task automatic test_normal();
        int w0 = n_wr, l0 = n_load, s0 = n_start;
        push(10); push(20); push(30); push(40);
        core_delay = 5; mv = 7; pos = 123;
        enable = 1'b1;
        for (int i = 0; i < 100 && n_wr == w0; i++) begin
            step();
            if (n_start > s0) enable = 1'b0;
        end
        step();
        n_tests++;
        if (n_wr !== w0 + 1 || n_load !== l0 + 4 || n_start !== s0 + 1) begin
            n_fail++;
            $display("FAIL normal_counts got wr=%0d load=%0d start=%0d want 1/4/1", n_wr - w0, n_load - l0, n_start - s0);
        end
        n_tests++;
        if (last_ld - first_ld !== 3) begin
            n_fail++;
            $display("FAIL normal_consecutive got span=%0d want 3", last_ld - first_ld);
        end
        n_tests++;
        if (qid_count !== 2'd1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_qid got qid_count=%0d running=%0d want 1/0", qid_count, running);
        end
    endtask

    task automatic test_starved();
        int w0 = n_wr, l0 = n_load, s0 = n_start, r0 = n_rden;
        push(1); push(2);
        core_delay = 3; mv = 50; pos = 60;
        enable = 1'b1;
        repeat (10) step();
        n_tests++;
        if (n_load !== l0 + 2 || n_start !== s0 || n_rden !== r0 + 2) begin
            n_fail++;
            $display("FAIL starved_stall got load=%0d start=%0d rden=%0d want 2/0/2", n_load - l0, n_start - s0, n_rden - r0);
        end
        push(3); push(4);
        for (int i = 0; i < 100 && n_wr == w0; i++) begin
            step();
            if (n_start > s0) enable = 1'b0;
        end
        step();
        n_tests++;
        if (n_load !== l0 + 4 || n_start !== s0 + 1 || n_rden !== r0 + 4 || n_wr !== w0 + 1) begin
            n_fail++;
            $display("FAIL starved_done got load=%0d start=%0d rden=%0d wr=%0d want 4/1/4/1",
                     n_load - l0, n_start - s0, n_rden - r0, n_wr - w0);
        end
    endtask

    task automatic test_backpressure();
        int w0 = n_wr, s0 = n_start;
        logic [31:0] hm, hp;
        logic [1:0]  hq;
        push(5); push(6); push(7); push(8);
        core_delay = 2; mv = 900; pos = 901; hm = mv; hp = pos;
        sink_fifo_full = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 100 && core_done !== 1'b1; i++) begin
            step();
            if (n_start > s0) enable = 1'b0;
        end
        step();
        hq = sink_qid;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (sink_fifo_wren !== 1'b0 || sink_minval !== hm || sink_position !== hp || sink_qid !== hq) begin
                n_fail++;
                $display("FAIL backpressure_hold got wren=%0d mv=%0d pos=%0d qid=%0d want 0/%0d/%0d/%0d",
                         sink_fifo_wren, sink_minval, sink_position, sink_qid, hm, hp, hq);
            end
            step();
        end
        sink_fifo_full = 1'b0;
        repeat (3) step();
        n_tests++;
        if (n_wr !== w0 + 1) begin
            n_fail++;
            $display("FAIL backpressure_single got wr=%0d want 1", n_wr - w0);
        end
    endtask

    task automatic test_timeout();
        int w0 = n_wr, a0 = n_abort, s0 = n_start;
        logic [1:0] q0 = qid_count;
        push(11); push(12); push(13); push(14);
        core_delay = 0;
        enable = 1'b1;
        for (int i = 0; i < 100 && n_abort == a0; i++) begin
            step();
            if (n_start > s0) enable = 1'b0;
        end
        repeat (3) step();
        n_tests++;
        if (n_abort !== a0 + 1 || abort_at !== 16) begin
            n_fail++;
            $display("FAIL timeout_abort got aborts=%0d at_wait=%0d want 1/16", n_abort - a0, abort_at);
        end
        n_tests++;
        if (err_timeout !== 1'b1 || running !== 1'b0 || qid_count !== q0 || n_wr !== w0) begin
            n_fail++;
            $display("FAIL timeout_state got err=%0d running=%0d qid=%0d wr=%0d want 1/0/%0d/0",
                     err_timeout, running, qid_count, n_wr - w0, q0);
        end
        do_reset();
        w0 = n_wr; a0 = n_abort; s0 = n_start;
        push(15); push(16); push(17); push(18);
        core_delay = 16; mv = 4; pos = 44;
        enable = 1'b1;
        for (int i = 0; i < 100 && n_wr == w0; i++) begin
            step();
            if (n_start > s0) enable = 1'b0;
        end
        step();
        n_tests++;
        if (n_wr !== w0 + 1 || n_abort !== a0 || err_timeout !== 1'b0 || qid_count !== 2'd1) begin
            n_fail++;
            $display("FAIL timeout_done_wins got wr=%0d aborts=%0d err=%0d qid=%0d want 1/0/0/1",
                     n_wr - w0, n_abort - a0, err_timeout, qid_count);
        end
    endtask

    task automatic test_back_to_back();
        int w0, s0, r0;
        do_reset();
        w0 = n_wr; s0 = n_start;
        for (int i = 0; i < 12; i++) push(16'(100 + i));
        core_delay = 2; mv = 300; pos = 301;
        enable = 1'b1;
        for (int i = 0; i < 300 && !(n_wr == w0 + 3 && running == 1'b0); i++) begin
            step();
            if (n_start >= s0 + 3) enable = 1'b0;
        end
        n_tests++;
        if (n_wr !== w0 + 3 || qid_count !== 2'd3 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_three got wr=%0d qid=%0d running=%0d want 3/3/0", n_wr - w0, qid_count, running);
        end
        w0 = n_wr; s0 = n_start; r0 = n_rden;
        for (int i = 0; i < 12; i++) push(16'(200 + i));
        enable = 1'b1;
        for (int i = 0; i < 300 && !(n_wr == w0 + 2 && running == 1'b0); i++) begin
            step();
            if (n_start >= s0 + 2) enable = 1'b0;
        end
        repeat (4) step();
        n_tests++;
        if (n_wr !== w0 + 2 || n_rden !== r0 + 8 || src_q.size() !== 4 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_disable got wr=%0d rden=%0d left=%0d running=%0d want 2/8/4/0",
                     n_wr - w0, n_rden - r0, src_q.size(), running);
        end
        n_tests++;
        if (qid_count !== 2'd1) begin
            n_fail++;
            $display("FAIL qid_wrap got qid_count=%0d want 1", qid_count);
        end
    endtask

    task automatic test_reset_mid_load();
        int l0, w0, s0;
        src_q.delete(); exp_ld.delete(); src_fifo_empty = 1'b1;
        l0 = n_load;
        push(21); push(22); push(23); push(24);
        enable = 1'b1;
        for (int i = 0; i < 50 && n_load < l0 + 2; i++) step();
        rst = 1'b1;
        step();
        n_tests++;
        if ({src_fifo_rden, core_load_en, core_load_addr, core_load_data, core_start, core_abort,
             sink_fifo_wren, sink_minval, sink_position, sink_qid, running, err_timeout, qid_count} !== '0) begin
            n_fail++;
            $display("FAIL midload_reset got running=%0d load_en=%0d addr=%0d qid=%0d want all 0",
                     running, core_load_en, core_load_addr, qid_count);
        end
        do_reset();
        w0 = n_wr; s0 = n_start;
        push(31); push(32); push(33); push(34);
        core_delay = 1; mv = 77; pos = 78;
        enable = 1'b1;
        for (int i = 0; i < 100 && n_wr == w0; i++) begin
            step();
            if (n_start > s0) enable = 1'b0;
        end
        step();
        n_tests++;
        if (n_wr !== w0 + 1 || qid_count !== 2'd1) begin
            n_fail++;
            $display("FAIL midload_restart got wr=%0d qid=%0d want 1/1", n_wr - w0, qid_count);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_starved();
        test_backpressure();
        test_timeout();
        test_back_to_back();
        test_reset_mid_load();
        n_tests++;
        if (exp_res.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_results got %0d want 0", exp_res.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
